// File: rtl/mem_access_if.sv
// Request/acknowledge data bus between the memory-access stage and the memory
// system. The stage is the master; the memory answers with ack and read data.
interface mem_access_if;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access.sv
// RV32 memory-access stage: turns one execute-stage request into a single bus
// transaction, extends load data and presents the write-back triple.
module mem_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  EX_MEM_addr,
  input  logic [3:0]   EX_MEM_rden,
  input  logic         EX_MEM_rden_SEXT,
  input  logic [3:0]   EX_MEM_wren,
  input  logic [31:0]  EX_MEM_wrdata,
  input  logic [4:0]   EX_rd,
  input  logic         EX_rd_vld,
  input  logic [31:0]  EX_x_rd,
  mem_access_if.master bus,
  output logic [4:0]   MEM_rd,
  output logic         MEM_rd_vld,
  output logic [31:0]  MEM_x_rd,
  output logic         mem_stall,
  output logic         mem_err
);

  typedef enum logic {IDLE, BUS} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        sext_q, sext_d;
  logic [4:0]  cap_rd_q, cap_rd_d;
  logic        cap_vld_q, cap_vld_d;
  logic [4:0]  mem_rd_q, mem_rd_d;
  logic        mem_vld_q, mem_vld_d;
  logic [31:0] mem_x_q, mem_x_d;
  logic        err_q, err_d;

  logic        access;
  logic        legal;
  logic        abort;
  logic [3:0]  mask;

  // Mask must be a word, an aligned half or a single byte matching addr[1:0].
  function automatic logic legal_mask(input logic [3:0] m, input logic [1:0] a);
    logic ok;
    case (m)
      4'b1111: ok = (a == 2'd0);
      4'b0011: ok = (a == 2'd0);
      4'b1100: ok = (a == 2'd2);
      4'b0001: ok = (a == 2'd0);
      4'b0010: ok = (a == 2'd1);
      4'b0100: ok = (a == 2'd2);
      4'b1000: ok = (a == 2'd3);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] load_extract(input logic [3:0]  m,
                                               input logic [31:0] rdata,
                                               input logic        sext);
    logic signed [15:0] half_s;
    logic signed [7:0]  byte_s;
    logic [31:0]        res;
    half_s = (m == 4'b1100) ? $signed(rdata[31:16]) : $signed(rdata[15:0]);
    case (m)
      4'b0010: byte_s = $signed(rdata[15:8]);
      4'b0100: byte_s = $signed(rdata[23:16]);
      4'b1000: byte_s = $signed(rdata[31:24]);
      default: byte_s = $signed(rdata[7:0]);
    endcase
    case (m)
      4'b0011, 4'b1100: res = sext ? 32'(half_s) : {16'h0000, half_s};
      4'b0001, 4'b0010,
      4'b0100, 4'b1000: res = sext ? 32'(byte_s) : {24'h000000, byte_s};
      default:          res = rdata;
    endcase
    return res;
  endfunction

  assign access = (EX_MEM_rden != 4'd0) || (EX_MEM_wren != 4'd0);
  assign mask   = (EX_MEM_wren != 4'd0) ? EX_MEM_wren : EX_MEM_rden;
  assign legal  = access && legal_mask(mask, EX_MEM_addr[1:0]);
  assign abort  = (state_q == BUS) && !bus.bus_ack && (cnt_q == TO_LAST);

  assign mem_stall = ((state_q == IDLE) && legal) ||
                     ((state_q == BUS) && !bus.bus_ack && !abort);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    addr_d    = addr_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    sext_d    = sext_q;
    cap_rd_d  = cap_rd_q;
    cap_vld_d = cap_vld_q;
    mem_rd_d  = mem_rd_q;
    mem_vld_d = 1'b0;
    mem_x_d   = mem_x_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!access) begin
          mem_rd_d  = EX_rd;
          mem_vld_d = EX_rd_vld && (EX_rd != 5'd0);
          mem_x_d   = EX_x_rd;
        end else if (legal) begin
          state_d   = BUS;
          cnt_d     = 16'd0;
          req_d     = 1'b1;
          addr_d    = {EX_MEM_addr[31:2], 2'b00};
          we_d      = (EX_MEM_wren != 4'd0);
          be_d      = mask;
          wdata_d   = EX_MEM_wrdata;
          sext_d    = EX_MEM_rden_SEXT;
          cap_rd_d  = EX_rd;
          cap_vld_d = EX_rd_vld;
        end else begin
          err_d = 1'b1;
        end
      end
      BUS: begin
        if (bus.bus_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (!we_q) begin
            mem_rd_d  = cap_rd_q;
            mem_vld_d = cap_vld_q && (cap_rd_q != 5'd0);
            mem_x_d   = load_extract(be_q, bus.bus_rdata, sext_q);
          end
        end else if (abort) begin
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      req_q     <= 1'b0;
      addr_q    <= 32'd0;
      we_q      <= 1'b0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      sext_q    <= 1'b0;
      cap_rd_q  <= 5'd0;
      cap_vld_q <= 1'b0;
      mem_rd_q  <= 5'd0;
      mem_vld_q <= 1'b0;
      mem_x_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      sext_q    <= sext_d;
      cap_rd_q  <= cap_rd_d;
      cap_vld_q <= cap_vld_d;
      mem_rd_q  <= mem_rd_d;
      mem_vld_q <= mem_vld_d;
      mem_x_q   <= mem_x_d;
      err_q     <= err_d;
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;
  assign MEM_rd        = mem_rd_q;
  assign MEM_rd_vld    = mem_vld_q;
  assign MEM_x_rd      = mem_x_q;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a table of single-instruction vectors with a
// bus responder, plus hand sequences for reset, idle ack and error pulse width.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] EX_MEM_addr;
  logic [3:0]  EX_MEM_rden;
  logic        EX_MEM_rden_SEXT;
  logic [3:0]  EX_MEM_wren;
  logic [31:0] EX_MEM_wrdata;
  logic [4:0]  EX_rd;
  logic        EX_rd_vld;
  logic [31:0] EX_x_rd;
  logic [4:0]  MEM_rd;
  logic        MEM_rd_vld;
  logic [31:0] MEM_x_rd;
  logic        mem_stall;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  mem_access_if bif ();

  mem_access #(.TIMEOUT(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .EX_MEM_addr      (EX_MEM_addr),
    .EX_MEM_rden      (EX_MEM_rden),
    .EX_MEM_rden_SEXT (EX_MEM_rden_SEXT),
    .EX_MEM_wren      (EX_MEM_wren),
    .EX_MEM_wrdata    (EX_MEM_wrdata),
    .EX_rd            (EX_rd),
    .EX_rd_vld        (EX_rd_vld),
    .EX_x_rd          (EX_x_rd),
    .bus              (bif),
    .MEM_rd           (MEM_rd),
    .MEM_rd_vld       (MEM_rd_vld),
    .MEM_x_rd         (MEM_x_rd),
    .mem_stall        (mem_stall),
    .mem_err          (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rden;
    logic        sext;
    logic [3:0]  wren;
    logic [31:0] wrdata;
    logic [4:0]  rd;
    logic        rd_vld;
    logic [31:0] x_rd;
    int          wait_n;   // ack in this bus cycle; 0 = never ack
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    int          e_stall;
    int          e_req;
    logic        e_vld;
    logic        chk_x;
    logic [31:0] e_x;
    logic        e_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    EX_MEM_addr      = 32'd0;
    EX_MEM_rden      = 4'd0;
    EX_MEM_rden_SEXT = 1'b0;
    EX_MEM_wren      = 4'd0;
    EX_MEM_wrdata    = 32'd0;
    EX_rd            = 5'd0;
    EX_rd_vld        = 1'b0;
    EX_x_rd          = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  stall_cnt;
    int  req_cnt;
    logic stall;
    logic done;
    string p;
    p = $sformatf("v%0d", idx);
    EX_MEM_addr      = v.addr;
    EX_MEM_rden      = v.rden;
    EX_MEM_rden_SEXT = v.sext;
    EX_MEM_wren      = v.wren;
    EX_MEM_wrdata    = v.wrdata;
    EX_rd            = v.rd;
    EX_rd_vld        = v.rd_vld;
    EX_x_rd          = v.x_rd;
    stall_cnt = 0;
    req_cnt   = 0;
    done      = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      if (bif.bus_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check({p, "_bus_addr"}, bif.bus_addr, v.e_addr);
          check({p, "_bus_be"}, 32'(bif.bus_be), 32'(v.e_be));
          check({p, "_bus_we"}, 32'(bif.bus_we), 32'(v.e_we));
          if (v.e_we) check({p, "_bus_wdata"}, bif.bus_wdata, v.wrdata);
        end
        if (req_cnt == v.wait_n) begin
          bif.bus_ack   = 1'b1;
          bif.bus_rdata = v.rdata;
        end
      end
      #1;
      stall = mem_stall;
      if (stall) stall_cnt++;
      step();
      bif.bus_ack   = 1'b0;
      bif.bus_rdata = 32'd0;
      if (!stall) done = 1'b1;
    end
    if (!done) check({p, "_guard"}, 32'd0, 32'd1);
    set_idle();
    check({p, "_stall_cycles"}, 32'(stall_cnt), 32'(v.e_stall));
    check({p, "_req_cycles"}, 32'(req_cnt), 32'(v.e_req));
    check({p, "_req_after"}, 32'(bif.bus_req), 32'd0);
    check({p, "_err"}, 32'(mem_err), 32'(v.e_err));
    check({p, "_rd_vld"}, 32'(MEM_rd_vld), 32'(v.e_vld));
    if (v.e_vld) check({p, "_rd"}, 32'(MEM_rd), 32'(v.rd));
    if (v.chk_x) check({p, "_x_rd"}, MEM_x_rd, v.e_x);
    step();
    check({p, "_err_gone"}, 32'(mem_err), 32'd0);
  endtask

  vec_t vecs[13];

  initial begin
    //            addr          rden    sx wren    wrdata        rd     vld x_rd          wt rdata         e_addr        e_be    we st rq vld cx e_x           err
    vecs[0]  = '{32'h0000_0000, 4'b0000, 0, 4'b0000, 32'h0,        5'd5,  1, 32'h0000_1234, 0, 32'h0,        32'h0,        4'b0000, 0, 0, 0, 1, 1, 32'h0000_1234, 0};
    vecs[1]  = '{32'h0000_0103, 4'b1000, 1, 4'b0000, 32'h0,        5'd7,  1, 32'h0000_5555, 1, 32'h80AA_BBCC, 32'h0000_0100, 4'b1000, 0, 1, 1, 1, 1, 32'hFFFF_FF80, 0};
    vecs[2]  = '{32'h0000_2002, 4'b1100, 0, 4'b0000, 32'h0,        5'd9,  1, 32'h0,         3, 32'hBEEF_0000, 32'h0000_2000, 4'b1100, 0, 3, 3, 1, 1, 32'h0000_BEEF, 0};
    vecs[3]  = '{32'h0000_0040, 4'b0000, 0, 4'b1111, 32'hDEAD_BEEF, 5'd0,  0, 32'h0,         2, 32'h0,        32'h0000_0040, 4'b1111, 1, 2, 2, 0, 0, 32'h0,         0};
    vecs[4]  = '{32'h0000_0041, 4'b1111, 0, 4'b0000, 32'h0,        5'd3,  1, 32'h0,         1, 32'h0,        32'h0,        4'b0000, 0, 0, 0, 0, 0, 32'h0,         1};
    vecs[5]  = '{32'h0000_0080, 4'b1111, 0, 4'b0000, 32'h0,        5'd4,  1, 32'h0,         0, 32'h0,        32'h0000_0080, 4'b1111, 0, 4, 4, 0, 0, 32'h0,         1};
    vecs[6]  = '{32'h0000_0010, 4'b0011, 1, 4'b0000, 32'h0,        5'd10, 1, 32'h0,         1, 32'h1234_8001, 32'h0000_0010, 4'b0011, 0, 1, 1, 1, 1, 32'hFFFF_8001, 0};
    vecs[7]  = '{32'h0000_0021, 4'b0010, 0, 4'b0000, 32'h0,        5'd11, 1, 32'h0,         2, 32'h0000_F500, 32'h0000_0020, 4'b0010, 0, 2, 2, 1, 1, 32'h0000_00F5, 0};
    vecs[8]  = '{32'h0000_0052, 4'b1111, 0, 4'b0100, 32'h00AA_0000, 5'd12, 1, 32'h0,         1, 32'h0,        32'h0000_0050, 4'b0100, 1, 1, 1, 0, 0, 32'h0,         0};
    vecs[9]  = '{32'h0000_0000, 4'b0000, 0, 4'b0000, 32'h0,        5'd0,  1, 32'h0000_0077, 0, 32'h0,        32'h0,        4'b0000, 0, 0, 0, 0, 1, 32'h0000_0077, 0};
    vecs[10] = '{32'h0000_0000, 4'b0101, 0, 4'b0000, 32'h0,        5'd2,  1, 32'h0,         1, 32'h0,        32'h0,        4'b0000, 0, 0, 0, 0, 0, 32'h0,         1};
    vecs[11] = '{32'h0000_0044, 4'b1111, 0, 4'b0000, 32'h0,        5'd13, 1, 32'h0,         4, 32'hCAFE_F00D, 32'h0000_0044, 4'b1111, 0, 4, 4, 1, 1, 32'hCAFE_F00D, 0};
    vecs[12] = '{32'h0000_2001, 4'b1100, 0, 4'b0000, 32'h0,        5'd14, 1, 32'h0,         1, 32'h0,        32'h0,        4'b0000, 0, 0, 0, 0, 0, 32'h0,         1};

    rst_n         = 1'b0;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = 32'd0;
    set_idle();
    step();
    step();

    // Reset state.
    check("rst_bus_req", 32'(bif.bus_req), 32'd0);
    check("rst_bus_addr", bif.bus_addr, 32'd0);
    check("rst_bus_be", 32'(bif.bus_be), 32'd0);
    check("rst_bus_we", 32'(bif.bus_we), 32'd0);
    check("rst_rd_vld", 32'(MEM_rd_vld), 32'd0);
    check("rst_x_rd", MEM_x_rd, 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      run_vec(i, vecs[i]);
    end

    // bus_ack while idle must not disturb a pass-through.
    EX_rd         = 5'd6;
    EX_rd_vld     = 1'b1;
    EX_x_rd       = 32'h0000_0099;
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'hFFFF_FFFF;
    #1;
    check("idle_ack_stall", 32'(mem_stall), 32'd0);
    step();
    bif.bus_ack = 1'b0;
    set_idle();
    check("idle_ack_req", 32'(bif.bus_req), 32'd0);
    check("idle_ack_vld", 32'(MEM_rd_vld), 32'd1);
    check("idle_ack_x", MEM_x_rd, 32'h0000_0099);
    step();

    // Reset in the second bus cycle abandons the load.
    EX_MEM_addr = 32'h0000_0100;
    EX_MEM_rden = 4'b1111;
    EX_rd       = 5'd8;
    EX_rd_vld   = 1'b1;
    step();
    check("rstbus_req_c1", 32'(bif.bus_req), 32'd1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_idle();
    check("rstbus_req", 32'(bif.bus_req), 32'd0);
    check("rstbus_addr", bif.bus_addr, 32'd0);
    check("rstbus_be", 32'(bif.bus_be), 32'd0);
    check("rstbus_vld", 32'(MEM_rd_vld), 32'd0);
    check("rstbus_err", 32'(mem_err), 32'd0);
    bif.bus_ack   = 1'b1;
    bif.bus_rdata = 32'h1111_2222;
    #1;
    check("rstbus_stall", 32'(mem_stall), 32'd0);
    step();
    bif.bus_ack = 1'b0;
    check("late_ack_vld", 32'(MEM_rd_vld), 32'd0);
    check("late_ack_req", 32'(bif.bus_req), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the RV32 core: the consumer of the execute stage's memory-request outputs (address, byte-lane read/write enables, sign-extend flag, write data). Converts each request into a single transaction on a req/ack data bus with variable wait states, extracts and sign/zero-extends load data, and delivers the write-back triple to the register file. It stalls the upstream pipeline while a transaction is outstanding and passes non-memory results through with one cycle of latency.

## Interface

- TIMEOUT, 255: maximum number of cycles `bus_req` stays high without `bus_ack` before the access is aborted (1..65535).

- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  synchronous reset, active low
- EX_MEM_addr  in  32  byte address of the access
- EX_MEM_rden  in  4  load byte-lane mask (0 = no load)
- EX_MEM_rden_SEXT  in  1  1 = sign-extend load result (lb/lh), 0 = zero-extend
- EX_MEM_wren  in  4  store byte-lane mask (0 = no store)
- EX_MEM_wrdata  in  32  lane-replicated store data
- EX_rd  in  5  destination register
- EX_rd_vld  in  1  destination write valid
- EX_x_rd  in  32  ALU result for non-load instructions
- bus_req  out  1  transaction request, held until ack or timeout
- bus_addr  out  32  word address {addr[31:2], 2'b00}
- bus_we  out  1  1 = write
- bus_be  out  4  byte enables (captured mask)
- bus_wdata  out  32  write data
- bus_ack  in  1  transaction complete; rdata valid in the same cycle
- bus_rdata  in  32  read data
- MEM_rd  out  5  write-back register
- MEM_rd_vld  out  1  write-back valid (forced 0 when MEM_rd = 0)
- MEM_x_rd  out  32  write-back data
- mem_stall  out  1  combinational; upstream holds all EX_* inputs stable while high
- mem_err  out  1  one-cycle pulse on illegal/misaligned access or timeout

## Operation

- States: IDLE, BUS.
- An access is present when EX_MEM_rden != 0 or EX_MEM_wren != 0. If both are nonzero, the store takes priority and the load mask is ignored.
- IDLE, no access: register EX_rd, EX_rd_vld, EX_x_rd into MEM_* on the next edge (pass-through).
- IDLE, legal access: capture address, mask, SEXT flag, wrdata, rd, and rd_vld; go to BUS; assert bus_req from the next cycle; MEM_rd_vld = 0 next cycle.
- Legal masks are 1111 (addr[1:0] = 00), 0011/1100 (addr[0] = 0), and single-bit masks. Any other mask, or a mismatch with addr[1:0], is illegal: no bus transaction, mem_err pulses next cycle, MEM_rd_vld = 0, state stays IDLE.
- BUS: bus_* outputs are stable. On bus_ack:
  - Load: select lanes from bus_rdata (word; half [15:0]/[31:16]; byte [8k+7:8k]), extend per SEXT, register into MEM_x_rd with the captured rd/rd_vld.
  - Store: MEM_rd_vld = 0.
  - Return to IDLE.
- Timeout counter: cleared on entry to BUS, incremented each BUS cycle without ack. When count reaches TIMEOUT with no ack: drop bus_req next cycle, pulse mem_err, MEM_rd_vld = 0, return to IDLE.
- bus_ack while in IDLE is ignored.
- mem_stall = (IDLE and legal access present) or (BUS and not bus_ack and not timeout-abort).

## Timing

- Reset (rst_n = 0 at edge): state IDLE, counter 0; bus_req, bus_we, bus_be, bus_addr, bus_wdata, MEM_rd, MEM_rd_vld, MEM_x_rd, and mem_err all 0. Reset during BUS abandons the access: bus_req is 0 from the next cycle and no write-back occurs.
- Pass-through latency: 1 cycle.
- Memory access, acceptance in cycle 0 and ack in cycle k (k >= 1):
  - bus_req is high in cycles 1..k.
  - mem_stall is high in cycles 0..k-1.
  - Write-back is visible in cycle k+1.
  - The state is IDLE in cycle k+1 and accepts the next instruction that cycle.
- Minimum access cost: 1 stall cycle.
- Timeout: bus_req is high for exactly TIMEOUT cycles; mem_err is high in the cycle after the last of them.

## Test plan

- Pass-through: EX_rd = 5, EX_rd_vld = 1, EX_x_rd = 0x1234, no masks -> next cycle MEM_rd = 5, MEM_rd_vld = 1, MEM_x_rd = 0x1234; mem_stall = 0.
- LB with sign extension: addr 0x103, rden 1000, SEXT = 1, rd = 7, ack in the first bus cycle with rdata 0x80AABBCC -> bus_addr 0x100, bus_be 1000, MEM_x_rd 0xFFFFFF80, MEM_rd_vld = 1, exactly 1 stall cycle.
- LHU with wait states: addr 0x2002, rden 1100, SEXT = 0, ack after 3 bus cycles, rdata 0xBEEF0000 -> bus_req high 3 cycles, MEM_x_rd 0x0000BEEF.
- SW: addr 0x40, wren 1111, wrdata 0xDEADBEEF -> bus_we = 1, bus_be 1111, bus_wdata 0xDEADBEEF; MEM_rd_vld stays 0.
- Misaligned LW: addr 0x41, rden 1111 -> no bus_req, mem_err pulses once, MEM_rd_vld 0. Timeout with TIMEOUT = 4 and no ack -> bus_req high 4 cycles, then mem_err pulse, return to IDLE.
- Reset mid-BUS: rst_n low during cycle 2 of an access -> all outputs 0 next cycle; a later ack is ignored.
